// File: rtl/ccsds_derandomizer_axis_if.sv
// 8-bit AXI-Stream bundle carrying codeword bytes between frame-processing stages.
// The master drives data/valid/last and the slave returns ready.
interface ccsds_derandomizer_axis_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ccsds_derandomizer_axis.sv
// CCSDS derandomizer: XORs each codeword byte with the reseeded pseudo-random sequence,
// enforces frame length and feeds a 2-entry skid buffer so input ready stays registered.
module ccsds_derandomizer_axis #(
    parameter int unsigned CODEWORD_LEN = 255,
    parameter logic [7:0]  LFSR_SEED    = 8'hFF
) (
    input  logic                            core_clk,
    input  logic                            rst_n,
    input  logic                            bypass_i,
    ccsds_derandomizer_axis_if.slave        s_axis,
    ccsds_derandomizer_axis_if.master       m_axis,
    output logic                            err_short_o,
    output logic                            err_long_o,
    output logic [15:0]                     frame_cnt_o,
    output logic [15:0]                     err_cnt_o
);

    localparam logic [7:0] LEN8 = 8'(CODEWORD_LEN);

    // State bit 7 is the next sequence bit; one call advances eight bits of h(x)=x^8+x^7+x^5+x^3+1.
    function automatic logic [7:0] lfsr_step8(input logic [7:0] s);
        logic [7:0] r;
        r = s;
        for (int i = 0; i < 8; i++) begin
            r = {r[6:0], r[7] ^ r[4] ^ r[2] ^ r[0]};
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [7:0]  idx_q, idx_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        byp_q, byp_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        err_short_q, err_short_d;
    logic        err_long_q, err_long_d;
    logic        s_tready_q, s_tready_d;
    logic [7:0]  m_data_q, m_data_d;
    logic        m_last_q, m_last_d;
    logic        m_valid_q, m_valid_d;
    logic [7:0]  skid_data_q, skid_data_d;
    logic        skid_last_q, skid_last_d;
    logic        skid_valid_q, skid_valid_d;

    logic        accept_s;
    logic [7:0]  pos_s;
    logic        end_s;
    logic [7:0]  key_s;
    logic        byp_s;
    logic [7:0]  in_data_s;
    logic        in_last_s;
    logic        out_free_s;

    assign accept_s   = s_axis.tvalid & s_tready_q;
    assign pos_s      = idx_q + 8'd1;
    assign end_s      = (pos_s == LEN8);
    assign key_s      = (idx_q == 8'd0) ? LFSR_SEED : lfsr_q;
    assign byp_s      = (idx_q == 8'd0) ? bypass_i : byp_q;
    assign in_data_s  = byp_s ? s_axis.tdata : (s_axis.tdata ^ key_s);
    assign in_last_s  = s_axis.tlast | end_s;
    assign out_free_s = ~m_valid_q | m_axis.tready;

    // Frame tracking, keystream advance, error detection and counters.
    always_comb begin
        idx_d       = idx_q;
        lfsr_d      = lfsr_q;
        byp_d       = byp_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        if (accept_s) begin
            lfsr_d      = lfsr_step8(key_s);
            byp_d       = byp_s;
            idx_d       = in_last_s ? 8'd0 : pos_s;
            err_short_d = s_axis.tlast & ~end_s;
            err_long_d  = ~s_axis.tlast & end_s;
            if (end_s) begin
                frame_cnt_d = sat_inc16(frame_cnt_q);
            end else begin
                frame_cnt_d = frame_cnt_q;
            end
            if (err_short_d | err_long_d) begin
                err_cnt_d = sat_inc16(err_cnt_q);
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Skid buffer: output slot refills from the skid entry first so byte order is preserved.
    always_comb begin
        m_data_d     = m_data_q;
        m_last_d     = m_last_q;
        m_valid_d    = m_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        skid_valid_d = skid_valid_q;
        if (out_free_s) begin
            if (skid_valid_q) begin
                m_data_d     = skid_data_q;
                m_last_d     = skid_last_q;
                m_valid_d    = 1'b1;
                skid_data_d  = in_data_s;
                skid_last_d  = in_last_s;
                skid_valid_d = accept_s;
            end else begin
                m_data_d     = accept_s ? in_data_s : m_data_q;
                m_last_d     = accept_s ? in_last_s : m_last_q;
                m_valid_d    = accept_s;
                skid_valid_d = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_data_d  = in_data_s;
                skid_last_d  = in_last_s;
                skid_valid_d = 1'b1;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
        s_tready_d = ~(m_valid_d & skid_valid_d);
    end

    // State registers; reset drops any partial frame and buffered bytes.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= 8'd0;
            lfsr_q       <= LFSR_SEED;
            byp_q        <= 1'b0;
            frame_cnt_q  <= 16'd0;
            err_cnt_q    <= 16'd0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
            s_tready_q   <= 1'b0;
            m_data_q     <= 8'd0;
            m_last_q     <= 1'b0;
            m_valid_q    <= 1'b0;
            skid_data_q  <= 8'd0;
            skid_last_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            lfsr_q       <= lfsr_d;
            byp_q        <= byp_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
            s_tready_q   <= s_tready_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
            m_valid_q    <= m_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign s_axis.tready = s_tready_q;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tlast  = m_last_q;
    assign m_axis.tvalid = m_valid_q;
    assign err_short_o   = err_short_q;
    assign err_long_o    = err_long_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_ccsds_derandomizer_axis.sv
// Scoreboard bench for ccsds_derandomizer_axis: a bit-level reference sequence predicts every
// output byte; a negedge monitor pops and compares transfers, stability and buffer occupancy.
module tb_ccsds_derandomizer_axis;
    localparam int LEN = 255;

    logic        core_clk = 1'b0;
    logic        rst_n;
    logic        bypass_i;
    logic        err_short_o, err_long_o;
    logic [15:0] frame_cnt_o, err_cnt_o;

    ccsds_derandomizer_axis_if s_if ();
    ccsds_derandomizer_axis_if m_if ();

    ccsds_derandomizer_axis #(.CODEWORD_LEN(LEN), .LFSR_SEED(8'hFF)) dut (
        .core_clk    (core_clk),
        .rst_n       (rst_n),
        .bypass_i    (bypass_i),
        .s_axis      (s_if.slave),
        .m_axis      (m_if.master),
        .err_short_o (err_short_o),
        .err_long_o  (err_long_o),
        .frame_cnt_o (frame_cnt_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 core_clk = ~core_clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  key_tab [LEN];
    logic [8:0]  sb [$];
    logic [8:0]  cap [$];
    logic [7:0]  txbuf [512];
    int          idx_m = 0;
    bit          byp_m = 1'b0;
    int          exp_frames = 0, exp_errs = 0, exp_short = 0, exp_long = 0;
    int          short_seen = 0, long_seen = 0;
    int          occ = 0;
    bit          chk_occ = 1'b0, bp_en = 1'b0, cap_en = 1'b0;
    bit          prev_stall = 1'b0, prev_short = 1'b0, prev_long = 1'b0;
    logic [7:0]  prev_data;
    logic        prev_last;

    // Reference sequence built bit by bit from a(n+8)=a(n+7)^a(n+5)^a(n+3)^a(n).
    task automatic build_keys();
        bit a [LEN*8];
        for (int i = 0; i < LEN*8; i++) a[i] = (i < 8) ? 1'b1 : (a[i-1] ^ a[i-3] ^ a[i-5] ^ a[i-8]);
        for (int b = 0; b < LEN; b++)
            for (int j = 0; j < 8; j++) key_tab[b][7-j] = a[8*b+j];
    endtask

    task automatic model_accept(input logic [7:0] d, input logic last);
        int pos;
        logic olast;
        logic [7:0] o;
        if (idx_m == 0) byp_m = bypass_i;
        pos   = idx_m + 1;
        o     = byp_m ? d : (d ^ key_tab[idx_m]);
        olast = last || (pos == LEN);
        if (last && pos < LEN) begin exp_short++; exp_errs++; end
        if (!last && pos == LEN) begin exp_long++; exp_errs++; end
        if (pos == LEN) exp_frames++;
        idx_m = olast ? 0 : pos;
        sb.push_back({olast, o});
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int n = 0;
        bit acc = 1'b0;
        s_if.tdata  = d;
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
        while (!acc && n < 1000) begin
            @(negedge core_clk);
            acc = s_if.tready;
            @(posedge core_clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout byte=%h never accepted", d);
        end else begin
            model_accept(d, last);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    // Sends txbuf[0..n-1]; tlast on byte last_at (0 = none); bypass_i cleared at byte clr_at.
    task automatic send_frame(input int n, input int last_at, input int clr_at);
        for (int i = 0; i < n; i++) begin
            if (clr_at != 0 && i + 1 == clr_at) bypass_i = 1'b0;
            send_byte(txbuf[i], (i + 1 == last_at));
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 5000) begin @(posedge core_clk); #1; n++; end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout %0d bytes still expected", sb.size());
        end
        repeat (3) @(posedge core_clk);
        #1;
    endtask

    // Output monitor: scoreboard pops, AXIS stability, pulse width and ready/occupancy agreement.
    always @(negedge core_clk) begin
        bit xfer, acc;
        logic [8:0] e;
        if (!rst_n) begin
            occ = 0; prev_stall = 1'b0; prev_short = 1'b0; prev_long = 1'b0;
        end else begin
            if (err_short_o) short_seen++;
            if (err_long_o) long_seen++;
            if ((err_short_o && prev_short) || (err_long_o && prev_long)) begin
                checks++; errors++;
                $display("FAIL err_pulse_width short=%b long=%b held for two cycles", err_short_o, err_long_o);
            end
            prev_short = err_short_o;
            prev_long  = err_long_o;
            if (prev_stall) begin
                checks++;
                if (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_data || m_if.tlast !== prev_last) begin
                    errors++;
                    $display("FAIL stall_stable got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             m_if.tvalid, m_if.tdata, m_if.tlast, prev_data, prev_last);
                end
            end
            if (chk_occ) begin
                checks++;
                if (s_if.tready !== (occ != 2)) begin
                    errors++;
                    $display("FAIL ready_vs_occupancy tready=%b want %b (held=%0d)", s_if.tready, (occ != 2), occ);
                end
            end
            xfer = m_if.tvalid && m_if.tready;
            acc  = s_if.tvalid && s_if.tready;
            if (xfer) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output d=%h l=%b with empty scoreboard", m_if.tdata, m_if.tlast);
                end else begin
                    e = sb.pop_front();
                    if ({m_if.tlast, m_if.tdata} !== e) begin
                        errors++;
                        $display("FAIL out_byte got l=%b d=%h want l=%b d=%h", m_if.tlast, m_if.tdata, e[8], e[7:0]);
                    end
                end
                if (cap_en) cap.push_back({m_if.tlast, m_if.tdata});
            end
            occ = occ + int'(acc) - int'(xfer);
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_data  = m_if.tdata;
            prev_last  = m_if.tlast;
        end
    end

    // Random 50% downstream ready while backpressure is enabled.
    always @(posedge core_clk) begin
        if (bp_en) begin
            #1;
            m_if.tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic test_reset();
        repeat (3) @(posedge core_clk);
        #1;
        checks++;
        if (s_if.tready !== 1'b0 || m_if.tvalid !== 1'b0 || m_if.tlast !== 1'b0 || m_if.tdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs tready=%b v=%b l=%b d=%h want 0 0 0 00", s_if.tready, m_if.tvalid, m_if.tlast, m_if.tdata);
        end
        checks++;
        if (frame_cnt_o !== 16'd0 || err_cnt_o !== 16'd0 || err_short_o !== 1'b0 || err_long_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_counters frame=%h err=%h s=%b l=%b want zeros", frame_cnt_o, err_cnt_o, err_short_o, err_long_o);
        end
        rst_n = 1'b1;
        @(posedge core_clk);
        #1;
        checks++;
        if (s_if.tready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b want 1", s_if.tready);
        end
    endtask

    task automatic test_zero_frame();
        logic [7:0] lit [8];
        lit = '{8'hFF, 8'h48, 8'h0E, 8'hC0, 8'h9A, 8'h0D, 8'h70, 8'hBC};
        cap.delete();
        cap_en = 1'b1;
        send_byte(8'h00, 1'b0);
        checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 8'hFF) begin
            errors++;
            $display("FAIL first_latency v=%b d=%h want v=1 d=ff", m_if.tvalid, m_if.tdata);
        end
        for (int i = 0; i < 254; i++) txbuf[i] = 8'h00;
        send_frame(254, 254, 0);
        drain();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cap.size() <= i || cap[i][7:0] !== lit[i]) begin
                errors++;
                $display("FAIL key_byte_%0d got %h want %h", i, (cap.size() > i) ? cap[i][7:0] : 8'hxx, lit[i]);
            end
        end
        checks++;
        if (cap.size() != 255 || cap[254][8] !== 1'b1 || cap[253][8] !== 1'b0) begin
            errors++;
            $display("FAIL zero_frame_tlast size=%0d want 255 with tlast only on byte 255", cap.size());
        end
        checks++;
        if (frame_cnt_o !== 16'd1 || err_cnt_o !== 16'd0 || short_seen != 0 || long_seen != 0) begin
            errors++;
            $display("FAIL zero_frame_counts frame=%0d err=%0d s=%0d l=%0d want 1 0 0 0", frame_cnt_o, err_cnt_o, short_seen, long_seen);
        end
        cap_en = 1'b0;
    endtask

    task automatic test_round_trip();
        logic [7:0] orig [LEN];
        int bad0 = 0, bad1 = 0;
        for (int i = 0; i < LEN; i++) orig[i] = 8'($urandom);
        cap.delete();
        cap_en = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < LEN; i++) txbuf[i] = orig[i] ^ key_tab[i];
            send_frame(LEN, LEN, 0);
        end
        drain();
        cap_en = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            if (cap.size() <= i || cap[i][7:0] !== orig[i]) bad0++;
            if (cap.size() <= LEN + i || cap[LEN+i][7:0] !== orig[i]) bad1++;
        end
        checks++;
        if (bad0 != 0 || bad1 != 0) begin
            errors++;
            $display("FAIL round_trip bad bytes frame1=%0d frame2=%0d want 0 0", bad0, bad1);
        end
        checks++;
        if (frame_cnt_o !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL round_trip_frames got %0d want %0d", frame_cnt_o, exp_frames);
        end
    endtask

    task automatic test_backpressure();
        chk_occ = 1'b1;
        bp_en   = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < LEN; i++) txbuf[i] = 8'($urandom);
            send_frame(LEN, LEN, 0);
        end
        drain();
        bp_en = 1'b0;
        @(posedge core_clk);
        #1;
        m_if.tready = 1'b1;
        chk_occ = 1'b0;
        checks++;
        if (frame_cnt_o !== 16'(exp_frames) || err_cnt_o !== 16'(exp_errs)) begin
            errors++;
            $display("FAIL bp_counts frame=%0d err=%0d want %0d %0d", frame_cnt_o, err_cnt_o, exp_frames, exp_errs);
        end
    endtask

    task automatic test_short_frame();
        int s0 = short_seen;
        cap.delete();
        cap_en = 1'b1;
        for (int i = 0; i < 100; i++) txbuf[i] = 8'($urandom);
        send_frame(100, 100, 0);
        for (int i = 0; i < LEN; i++) txbuf[i] = 8'h00;
        send_frame(LEN, LEN, 0);
        drain();
        cap_en = 1'b0;
        checks++;
        if (short_seen - s0 != 1 || err_cnt_o !== 16'd1 || err_cnt_o !== 16'(exp_errs)) begin
            errors++;
            $display("FAIL short_frame pulses=%0d err_cnt=%0d want 1 1", short_seen - s0, err_cnt_o);
        end
        checks++;
        if (cap.size() < 101 || cap[99][8] !== 1'b1 || cap[100][7:0] !== 8'hFF) begin
            errors++;
            $display("FAIL short_then_reseed size=%0d want tlast on byte 100 and next byte ff", cap.size());
        end
        checks++;
        if (frame_cnt_o !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL short_frame_count got %0d want %0d", frame_cnt_o, exp_frames);
        end
    endtask

    task automatic test_long_frame();
        int l0 = long_seen;
        cap.delete();
        cap_en = 1'b1;
        for (int i = 0; i < 300; i++) txbuf[i] = 8'h00;
        send_frame(300, 0, 0);
        drain();
        cap_en = 1'b0;
        checks++;
        if (long_seen - l0 != 1 || err_cnt_o !== 16'(exp_errs) || frame_cnt_o !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL long_frame pulses=%0d err=%0d frame=%0d want 1 %0d %0d", long_seen - l0, err_cnt_o, frame_cnt_o, exp_errs, exp_frames);
        end
        checks++;
        if (cap.size() != 300 || cap[254][8] !== 1'b1 || cap[255][7:0] !== 8'hFF || cap[256][7:0] !== 8'h48 || cap[257][7:0] !== 8'h0E) begin
            errors++;
            $display("FAIL long_frame_reseed size=%0d want tlast on 255 then ff 48 0e", cap.size());
        end
        for (int i = 0; i < 210; i++) txbuf[i] = 8'($urandom);
        send_frame(210, 210, 0);
        drain();
    endtask

    task automatic test_bypass_reset();
        int bad = 0;
        cap.delete();
        cap_en = 1'b1;
        bypass_i = 1'b1;
        for (int i = 0; i < LEN; i++) txbuf[i] = 8'($urandom);
        send_frame(LEN, LEN, 100);
        drain();
        cap_en = 1'b0;
        for (int i = 0; i < LEN; i++) if (cap.size() <= i || cap[i][7:0] !== txbuf[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bypass_frame %0d modified bytes want 0", bad);
        end
        for (int i = 0; i < 49; i++) txbuf[i] = 8'($urandom);
        send_frame(49, 0, 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_if.tvalid !== 1'b0 || m_if.tdata !== 8'h00 || m_if.tlast !== 1'b0 || frame_cnt_o !== 16'd0 || err_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL midframe_reset v=%b d=%h l=%b frame=%0d err=%0d want all zero", m_if.tvalid, m_if.tdata, m_if.tlast, frame_cnt_o, err_cnt_o);
        end
        repeat (2) @(posedge core_clk);
        #1;
        sb.delete();
        idx_m = 0; exp_frames = 0; exp_errs = 0;
        rst_n = 1'b1;
        @(posedge core_clk);
        #1;
        cap.delete();
        cap_en = 1'b1;
        send_byte(8'h00, 1'b0);
        drain();
        cap_en = 1'b0;
        checks++;
        if (cap.size() != 1 || cap[0] !== 9'h0FF) begin
            errors++;
            $display("FAIL after_reset_byte1 size=%0d want one byte ff", cap.size());
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bypass_i    = 1'b0;
        s_if.tdata  = 8'h00;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        build_keys();
        test_reset();
        test_zero_frame();
        test_round_trip();
        test_backpressure();
        test_short_frame();
        test_long_frame();
        test_bypass_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ccsds_derandomizer_axis.md
Name: ccsds_derandomizer_axis

Overview:
- Sits directly downstream of the sync-marker detector; ASM is already stripped there.
- Consumes the 8-bit AXI-Stream codeword stream, with one frame per CODEWORD_LEN bytes and tlast on the final byte.
- XORs each byte with the CCSDS pseudo-random sequence, re-seeded at every frame start, and forwards the result to the RS decoder stage.
- Enforces frame length, flags short or long frames, and keeps saturating frame and error counters.

Parameters:
- CODEWORD_LEN, 255: bytes per frame. Legal range 2..255.
- LFSR_SEED, 8'hFF: LFSR state loaded at every frame start.

Ports:
- core_clk  in  1  single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- bypass_i  in  1  1 = pass data unmodified; sampled only at frame start.
- s_axis_tdata  in  8  input byte.
- s_axis_tvalid  in  1  input valid.
- s_axis_tlast  in  1  input end of frame.
- s_axis_tready  out  1  input ready; registered.
- m_axis_tdata  out  8  derandomized byte.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  output end of frame.
- m_axis_tready  in  1  downstream ready.
- err_short_o  out  1  one-cycle pulse: input tlast arrived before byte CODEWORD_LEN.
- err_long_o  out  1  one-cycle pulse: byte CODEWORD_LEN arrived without tlast.
- frame_cnt_o  out  16  completed frames, saturating at 16'hFFFF.
- err_cnt_o  out  16  short plus long errors, saturating at 16'hFFFF.

Behaviour:
- Reset (rst_n low, asynchronous):
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - s_axis_tready=0 while rst_n low, then 1 on the first clock after release.
  - err pulses=0, both counters=0, LFSR=LFSR_SEED, byte index=0.
- Reset mid-frame discards the partial frame and any buffered bytes. The next accepted byte is byte 1 of a new frame.
- Handshake:
  - Input accepted when s_axis_tvalid & s_axis_tready.
  - Output transfer when m_axis_tvalid & m_axis_tready.
  - Full AXIS rules: m_axis_tdata/tlast held stable while tvalid=1 and tready=0.
- Buffering: 2-entry skid buffer, so s_axis_tready is a register and never combinationally depends on m_axis_tready.
  - s_axis_tready deasserts only when both entries are occupied.
  - Sustained 1 byte/clock with m_axis_tready held high.
- Latency: an accepted byte appears on m_axis with tvalid=1 on the next clock when the buffer is empty.
- LFSR:
  - Fibonacci form, h(x)=x^8+x^7+x^5+x^3+1, advanced 8 bits per accepted byte.
  - Output MSB-first: bit 7 of the key = first sequence bit.
  - From seed 8'hFF the key bytes are FF 48 0E C0 9A 0D 70 BC …, with period 255 bytes.
  - LFSR advances only on input accept, never on stall.
- Data: m_axis_tdata = s_axis_tdata XOR key, or unmodified when the frame's latched bypass=1. The LFSR still advances in bypass.
- Frame tracking: byte index counts 1..CODEWORD_LEN on accepted bytes.
  - At index=0 (frame start): LFSR is loaded with LFSR_SEED before XOR of byte 1, and bypass_i is latched.
- Normal end: input tlast on byte CODEWORD_LEN.
  - m_axis_tlast=1 on that byte.
  - index←0, frame_cnt+1.
- Short frame: input tlast on byte k<CODEWORD_LEN.
  - Byte forwarded with m_axis_tlast=1; err_short_o pulses the cycle after accept.
  - err_cnt+1, index←0, frame_cnt unchanged.
- Long frame: byte CODEWORD_LEN accepted with input tlast=0.
  - m_axis_tlast forced to 1; err_long_o pulses; err_cnt+1; frame_cnt+1.
  - index←0, so the next byte reseeds and starts a new frame.
- Simultaneous short/long is impossible: one condition per byte. Error pulses are independent of m_axis_tready.
- Counters hold at 16'hFFFF; no wrap.
- Mid-frame changes on bypass_i are ignored until the next frame start.

Test Plan:
- Zero frame, CODEWORD_LEN=255, m_axis_tready=1: 255 bytes of 8'h00 with tlast on byte 255 -> output FF 48 0E C0 9A 0D 70 BC … with tlast on byte 255, 1-cycle latency, frame_cnt=1, no error pulses.
- Round trip: randomized frame (data XOR sequence) followed by a second identical frame -> both recover the original data. Confirms reseed at each frame start.
- Backpressure: m_axis_tready toggling randomly at 50% over 3 frames -> output data identical to the no-stall run, no byte lost or duplicated, tdata stable while stalled, s_axis_tready low only when 2 entries are held.
- Short frame: tlast on byte 100 -> output tlast on byte 100, err_short_o 1-cycle pulse, err_cnt=1. Next frame's byte 1 XORed with FF.
- Long frame: 300 bytes, no tlast -> m_axis_tlast on byte 255, err_long_o pulse, bytes 256..300 XORed with FF 48 0E ….
- Bypass and reset: bypass_i=1 at frame start, toggled to 0 mid-frame -> whole frame unmodified. rst_n pulsed low at byte 50 of the next frame -> outputs and counters cleared; the following byte is XORed with FF.
